// File: rtl/frame_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tx_ctrl
//  Description : Frame-level transmit sequencer. Walks one buffered frame line
//                by line: prefetches each line from the frame buffer, then
//                requests one UDP packet for it. Ends every frame (normal or
//                timed out) with a single-cycle frame_over pulse, then waits
//                for the enable level to drop before accepting a new frame.
//  Options     : FRAME_SEQ_EN - adds frame_seq (frame counter) and pkt_last
//                (last-line flag) outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int BPP             = 2,
    parameter int HDR_BYTES       = 4,
    parameter int LINE_W          = 10,
    parameter int PREFETCH_CYCLES = 16,
    parameter int IPG_CYCLES      = 12,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic              tx_clk,
    input  logic              rst_n,
    input  logic              frame_send_en,
    input  logic              buf_frame_ready,
    input  logic              udp_tx_busy,
    input  logic              udp_tx_done,
    output logic              rd_line_start,
    output logic              udp_tx_req,
    output logic [15:0]       udp_tx_len,
    output logic [LINE_W-1:0] pkt_line,
    output logic              busy,
    output logic              tx_err,
`ifdef FRAME_SEQ_EN
    output logic [15:0]       frame_seq,
    output logic              pkt_last,
`endif
    output logic              frame_over
);

    // ------------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------------
    // One shared counter times both the prefetch wait and the inter-packet gap.
    localparam int CNT_MAX = (PREFETCH_CYCLES > IPG_CYCLES) ? PREFETCH_CYCLES : IPG_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // Timeout timer only ever needs to hold TIMEOUT_CYCLES-1.
    localparam int TMR_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  c_pf_last   = CNT_W'(PREFETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_ipg_last  = CNT_W'(IPG_CYCLES - 1);
    localparam logic [TMR_W-1:0]  c_tmo_last  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LINE_W-1:0] c_line_last = LINE_W'(V_ACTIVE - 1);
    localparam logic [15:0]       c_pkt_len   = 16'(H_ACTIVE * BPP + HDR_BYTES);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BUF  = 3'd1,
        S_PREFETCH  = 3'd2,
        S_REQ       = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_GAP       = 3'd5,
        S_FINISH    = 3'd6,
        S_HOLD      = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [TMR_W-1:0]  tmr_q,   tmr_d;
    logic [LINE_W-1:0] line_q,  line_d;
    logic              err_q,   err_d;
    logic              rd_q,    rd_d;
    logic              req_q,   req_d;
    logic              fo_q,    fo_d;
    logic              busy_q,  busy_d;

    // Next-state, counter and line-index logic for the frame walk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        line_d  = line_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (frame_send_en) begin
                    state_d = S_WAIT_BUF;
                    line_d  = '0;
                    err_d   = 1'b0;
                end
            end

            S_WAIT_BUF: begin
                if (buf_frame_ready) begin
                    state_d = S_PREFETCH;
                    cnt_d   = '0;
                end
            end

            S_PREFETCH: begin
                if (cnt_q == c_pf_last) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            S_REQ: begin
                if (!udp_tx_busy) begin
                    state_d = S_WAIT_DONE;
                    tmr_d   = '0;
                end
            end

            S_WAIT_DONE: begin
                // Done is tested first so it wins over a coincident timeout.
                if (udp_tx_done) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (tmr_q == c_tmo_last) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == c_ipg_last) begin
                    cnt_d = '0;
                    if (line_q == c_line_last) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_PREFETCH;
                        line_d  = line_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FINISH: begin
                state_d = S_HOLD;
            end

            S_HOLD: begin
                // A still-high enable must not launch a second frame.
                if (!frame_send_en) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output pulses derived from the transition being taken, so they register
    // alongside the state they belong to.
    always_comb begin
        rd_d   = (state_d == S_PREFETCH) && (state_q != S_PREFETCH);
        req_d  = (state_q == S_REQ) && (state_d == S_WAIT_DONE);
        fo_d   = (state_d == S_FINISH);
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge tx_clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            req_q   <= 1'b0;
            fo_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            line_q  <= line_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            req_q   <= req_d;
            fo_q    <= fo_d;
            busy_q  <= busy_d;
        end
    end

    assign rd_line_start = rd_q;
    assign udp_tx_req    = req_q;
    assign udp_tx_len    = c_pkt_len;
    assign pkt_line      = line_q;
    assign busy          = busy_q;
    assign tx_err        = err_q;
    assign frame_over    = fo_q;

`ifdef FRAME_SEQ_EN
    logic [15:0] seq_q;
    logic        last_q;

    // Frame counter bumps after each frame_over pulse; last-line flag tracks
    // the registered line index.
    always_ff @(posedge tx_clk) begin
        if (!rst_n) begin
            seq_q  <= '0;
            last_q <= 1'b0;
        end else begin
            if (fo_q) begin
                seq_q <= seq_q + 16'd1;
            end
            last_q <= (line_d == c_line_last);
        end
    end

    assign frame_seq = seq_q;
    assign pkt_last  = last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_tx_ctrl
//  Description : Self-checking bench for frame_tx_ctrl. Each frame is planned
//                up front (buffer delay, busy stall, done delay, timeout,
//                abort); the expected event times are computed arithmetically
//                from the frame rules and every cycle's outputs are compared.
//                Define FRAME_SEQ_EN to also check frame_seq / pkt_last.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_tx_ctrl;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int BPP = 2;
    localparam int HDR = 4;
    localparam int LW  = 10;
    localparam int P   = 2;
    localparam int IPG = 3;
    localparam int T   = 20;

    logic          tx_clk          = 1'b0;
    logic          rst_n           = 1'b0;
    logic          frame_send_en   = 1'b0;
    logic          buf_frame_ready = 1'b0;
    logic          udp_tx_busy     = 1'b0;
    logic          udp_tx_done     = 1'b0;
    logic          rd_line_start;
    logic          udp_tx_req;
    logic [15:0]   udp_tx_len;
    logic [LW-1:0] pkt_line;
    logic          busy;
    logic          tx_err;
    logic          frame_over;
`ifdef FRAME_SEQ_EN
    logic [15:0]   frame_seq;
    logic          pkt_last;
`endif

    int n_total   = 0;
    int n_bad     = 0;
    int cyc       = 0;
    int prev_line = 0;
    bit prev_err  = 1'b0;
    int seq_exp   = 0;
    int pb[V];
    int pdd[V];

    frame_tx_ctrl #(
        .H_ACTIVE        (H),
        .V_ACTIVE        (V),
        .BPP             (BPP),
        .HDR_BYTES       (HDR),
        .LINE_W          (LW),
        .PREFETCH_CYCLES (P),
        .IPG_CYCLES      (IPG),
        .TIMEOUT_CYCLES  (T)
    ) u_dut (
        .tx_clk          (tx_clk),
        .rst_n           (rst_n),
        .frame_send_en   (frame_send_en),
        .buf_frame_ready (buf_frame_ready),
        .udp_tx_busy     (udp_tx_busy),
        .udp_tx_done     (udp_tx_done),
        .rd_line_start   (rd_line_start),
        .udp_tx_req      (udp_tx_req),
        .udp_tx_len      (udp_tx_len),
        .pkt_line        (pkt_line),
        .busy            (busy),
        .tx_err          (tx_err),
`ifdef FRAME_SEQ_EN
        .frame_seq       (frame_seq),
        .pkt_last        (pkt_last),
`endif
        .frame_over      (frame_over)
    );

    always #5 tx_clk = ~tx_clk;

    // Safety net: the plan always ends on its own, this only catches a hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge tx_clk);
        cyc++;
    endtask

    task automatic check_cycle(input bit eb, input bit er, input bit eq, input bit ef,
                               input bit ee, input int el);
        check_eq("outs",
                 {17'd0, busy, rd_line_start, udp_tx_req, frame_over, tx_err, pkt_line},
                 {17'd0, eb, er, eq, ef, ee, LW'(el)});
`ifdef FRAME_SEQ_EN
        check_eq("seq_last", {15'd0, pkt_last, frame_seq}, {15'd0, (el == V - 1), 16'(seq_exp)});
        if (ef) seq_exp++;
`endif
    endtask

    // Plans one frame from the per-line pb/pdd arrays and checks it cycle by
    // cycle. to_line >= 0 withholds done on that line; abort_line >= 0 pulls
    // reset two cycles into that line's wait for done.
    task automatic run_frame(input int bd, input int to_line, input int hold,
                             input int abort_line, input bit spur, input bit en_drop);
        int r[V];
        int q[V];
        int f, last, idle_c, ab, t0, c, el;
        bit is_to, is_ab, eb, er, eq, ef, ee, skip;
        for (int i = 0; i < V; i++) begin
            r[i] = -1000;
            q[i] = -1000;
        end
        t0    = cyc;
        is_to = (to_line >= 0);
        is_ab = (abort_line >= 0);
        r[0]  = t0 + (((bd + 1) > 2) ? (bd + 1) : 2);
        last  = V - 1;
        f     = -1000;
        ab    = -1000;
        for (int i = 0; i < V; i++) begin
            q[i] = r[i] + P + 1 + pb[i];
            if (is_ab && i == abort_line) begin
                ab   = q[i] + 2;
                last = i;
                break;
            end
            if (is_to && i == to_line) begin
                f    = q[i] + T;
                last = i;
                break;
            end
            if (i == V - 1) f = q[i] + pdd[i] + IPG;
            else            r[i + 1] = q[i] + pdd[i] + IPG;
        end
        if (en_drop) hold = 1;
        idle_c = f + hold + 1;

        check_eq("len", {16'd0, udp_tx_len}, 32'(H * BPP + HDR));

        forever begin
            c  = cyc;
            eb = is_ab ? (c >= t0 + 1 && c <= ab) : (c >= t0 + 1 && c < idle_c);
            er = 1'b0;
            eq = 1'b0;
            for (int i = 0; i <= last; i++) begin
                if (c == r[i]) er = 1'b1;
                if (c == q[i]) eq = 1'b1;
            end
            ef = !is_ab && (c == f);
            if (c <= t0) begin
                ee = prev_err;
                el = prev_line;
            end else begin
                ee = is_to && (c >= f);
                el = 0;
                for (int i = 1; i <= last; i++) if (c >= r[i]) el = i;
            end
            if (is_ab && c > ab) begin
                ee = 1'b0;
                el = 0;
                seq_exp = 0;
            end
            check_cycle(eb, er, eq, ef, ee, el);

            if (!is_ab && c == idle_c) break;
            if (is_ab && c == ab + 2) begin
                rst_n = 1'b1;
                break;
            end

            // Drive inputs sampled at the next rising edge.
            if (is_ab)        frame_send_en = 1'b1;
            else if (en_drop) frame_send_en = (c < t0 + 2);
            else              frame_send_en = (c < f + hold);
            buf_frame_ready = (c >= t0 + bd) && (is_ab ? (c < ab) : (c < f));
            udp_tx_busy = 1'b0;
            udp_tx_done = 1'b0;
            for (int i = 0; i <= last; i++) begin
                skip = (is_to && i == to_line) || (is_ab && i == abort_line);
                if (pb[i] > 0 && c >= r[i] && c < r[i] + P + pb[i]) udp_tx_busy = 1'b1;
                if (!skip && c == q[i] + pdd[i] - 1) udp_tx_done = 1'b1;
                if (spur && c == r[i]) udp_tx_done = 1'b1;
                if (spur && !skip && c == q[i] + pdd[i] + 1) udp_tx_done = 1'b1;
            end
            if (is_ab && c >= ab) begin
                rst_n           = 1'b0;
                buf_frame_ready = 1'b0;
                udp_tx_busy     = 1'b0;
                udp_tx_done     = 1'b0;
            end
            tick;
        end
        prev_line = is_ab ? 0 : last;
        prev_err  = is_ab ? 1'b0 : is_to;
    endtask

    task automatic set_plan(input int b, input int d);
        for (int i = 0; i < V; i++) begin
            pb[i]  = b;
            pdd[i] = d;
        end
    endtask

    initial begin
        int to_line;
        // Reset state.
        repeat (3) tick;
        check_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_eq("len_rst", {16'd0, udp_tx_len}, 32'd12);
        rst_n = 1'b1;
        tick;
        check_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Nominal frame.
        set_plan(0, 5);
        run_frame(0, -1, 1, -1, 1'b0, 1'b0);
        // Buffer and backpressure stall.
        set_plan(7, 5);
        run_frame(10, -1, 1, -1, 1'b0, 1'b0);
        // Timeout on line 1.
        set_plan(0, 5);
        run_frame(0, 1, 1, -1, 1'b0, 1'b0);
        // Stale enable held 50 cycles after frame_over; error clears at start.
        run_frame(0, -1, 50, -1, 1'b0, 1'b0);
        // Fresh frame after dropping the enable.
        run_frame(0, -1, 1, -1, 1'b0, 1'b0);
        // Reset in WAIT_DONE of line 1, then restart with enable still high.
        pdd[1] = 8;
        run_frame(0, -1, 1, 1, 1'b0, 1'b0);
        set_plan(0, 5);
        run_frame(0, -1, 1, -1, 1'b0, 1'b0);
        // Done coinciding with timeout: done wins.
        set_plan(1, T);
        run_frame(2, -1, 2, -1, 1'b1, 1'b0);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < V; i++) begin
                pb[i]  = int'($urandom_range(0, 4));
                pdd[i] = int'($urandom_range(1, T));
            end
            to_line = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, V - 1)) : -1;
            run_frame(int'($urandom_range(0, 6)), to_line, int'($urandom_range(1, 6)), -1,
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_tx_ctrl.md
Name: frame_tx_ctrl

Overview:
- Frame-level transmit sequencer; the consumer of `frame_send_en` and the producer of `frame_over` in the camera-to-Ethernet path.
- When enabled, it walks one buffered image frame line by line. For each line it prefetches the line from the frame buffer and requests one UDP packet from the UDP transmitter.
- After the last line (or on an error) it pulses `frame_over` for one cycle, which clears the enable at the source.

Parameters:
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- BPP, 2, bytes per pixel
- HDR_BYTES, 4, per-packet payload header bytes (line number + flags)
- LINE_W, 10, width of line index
- PREFETCH_CYCLES, 16, wait after `rd_line_start` before requesting the packet
- IPG_CYCLES, 12, idle cycles between packets
- TIMEOUT_CYCLES, 65535, maximum wait for `udp_tx_done`

Ports:
- tx_clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- frame_send_en  in  1  level request to send one frame
- buf_frame_ready  in  1  frame buffer holds a complete frame
- udp_tx_busy  in  1  UDP transmitter cannot accept a request
- udp_tx_done  in  1  one-cycle pulse: current packet fully sent
- rd_line_start  out  1  one-cycle pulse: buffer begins prefetch of `pkt_line`
- udp_tx_req  out  1  one-cycle pulse: send one packet
- udp_tx_len  out  16  payload length = H_ACTIVE*BPP + HDR_BYTES, constant
- pkt_line  out  LINE_W  line index of current packet
- busy  out  1  high in every state except IDLE
- tx_err  out  1  sticky timeout flag; cleared on next frame start
- frame_over  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: `rst_n`=0 at a clock edge forces the following, with no `frame_over` emitted; reset mid-frame abandons the frame.
  - State to IDLE.
  - `rd_line_start`, `udp_tx_req`, `frame_over`, `busy` and `tx_err` to 0.
  - `pkt_line` to 0 and all counters to 0.
- `udp_tx_len` is a constant, independent of reset.
- States and transitions:
  - IDLE: when `frame_send_en`=1 → WAIT_BUF. On that edge `pkt_line`←0 and `tx_err`←0.
  - WAIT_BUF: when `buf_frame_ready`=1 → PREFETCH, asserting `rd_line_start` for exactly the first PREFETCH cycle.
  - PREFETCH: counts PREFETCH_CYCLES cycles, then → REQ.
  - REQ: when `udp_tx_busy`=0 → `udp_tx_req`=1 for one cycle → WAIT_DONE, timeout timer cleared. Holds REQ while busy.
  - WAIT_DONE: on `udp_tx_done` → GAP. If the timer reaches TIMEOUT_CYCLES-1 without done → `tx_err`←1 → FINISH. If done and timeout coincide, done wins.
  - GAP: counts IPG_CYCLES cycles. If `pkt_line`=V_ACTIVE-1 → FINISH; else `pkt_line`+1 → PREFETCH with a new `rd_line_start` pulse.
  - FINISH: `frame_over`=1 for exactly one cycle → HOLD.
  - HOLD: waits for `frame_send_en`=0 → IDLE. This prevents a second frame from a stale enable level.
- `frame_send_en` is sampled only in IDLE and HOLD. A deassertion mid-frame is ignored and the frame completes.
- A `udp_tx_done` pulse outside WAIT_DONE is ignored.
- `pkt_line` never exceeds V_ACTIVE-1; there is no wrap.
- Latency, IDLE→first `udp_tx_req` with buffer ready and UDP idle: 1 (WAIT_BUF) + PREFETCH_CYCLES + 1 cycles.
- All outputs are registered.

Optional Feature:
- FRAME_SEQ_EN defined:
  - Adds output `frame_seq` [15:0], reset 0.
  - Increments by 1 (mod 2^16) on each `frame_over` pulse, including error-terminated frames.
  - Adds output `pkt_last`, high while `pkt_line`=V_ACTIVE-1, so the UDP transmitter can flag the end of frame in the header.
- FRAME_SEQ_EN undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Test Plan:
All scenarios use H_ACTIVE=4, V_ACTIVE=3, BPP=2, PREFETCH_CYCLES=2, IPG_CYCLES=3, TIMEOUT_CYCLES=20.
- Nominal frame: `frame_send_en`=1, `buf_frame_ready`=1, UDP idle, done 5 cycles after each req → 3 `udp_tx_req` pulses with `pkt_line` 0,1,2, `udp_tx_len`=12, 3 `rd_line_start` pulses, one `frame_over` pulse, `tx_err`=0.
- Buffer/backpressure stall: `buf_frame_ready`=0 for 10 cycles, then `udp_tx_busy`=1 for 7 cycles at REQ → no req while stalled; req issues the cycle after busy falls; frame still completes with 3 packets.
- Timeout: no `udp_tx_done` for line 1 → `tx_err`=1 at 20 cycles after req; `frame_over` pulses once; line 2 never requested; `tx_err` clears on the next frame start.
- Stale enable: hold `frame_send_en`=1 for 50 cycles after `frame_over` → block stays in HOLD with no new req. Drop then raise enable → a new frame starts at line 0.
- Reset mid-frame: `rst_n`=0 during WAIT_DONE of line 1 → next cycle all outputs 0 and no `frame_over`. With enable still high after reset release, the frame restarts at line 0.
- FRAME_SEQ_EN: two nominal frames → `frame_seq` goes 0→1→2; `pkt_last`=1 only while `pkt_line`=2.
